accum_write_control: RTL
========================

ACCUM_WRITE_CONTROL -- requirements
Module: accum_write_control

Interface
REQ-001 SHALL have parameter SYS_ARR_ROWS, default 16: systolic array rows.
REQ-002 SHALL have parameter SYS_ARR_COLS, default 16: systolic array columns.
REQ-003 SHALL have parameter MAX_OUT_ROWS, default 128: output matrix max rows.
REQ-004 SHALL have parameter MAX_OUT_COLS, default 128: output matrix max cols.
REQ-005 SHALL have parameter LATENCY, default 16, legal range ≥1: cycles from start until column 0, row 0 result is valid.
REQ-006 SHALL derive AW = $clog2(MAX_OUT_ROWS*(MAX_OUT_COLS/SYS_ARR_COLS)) as the accumulator address width (default 10).
REQ-007 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-009 SHALL have port start, input, 1 bit: launch one submatrix write pass.
REQ-010 SHALL have port submat_row_in, input, $clog2(MAX_OUT_ROWS/SYS_ARR_ROWS) bits: output submatrix row index.
REQ-011 SHALL have port submat_col_in, input, $clog2(MAX_OUT_COLS/SYS_ARR_COLS) bits: output submatrix column index.
REQ-012 SHALL have port num_rows_in, input, $clog2(SYS_ARR_ROWS) bits: valid rows minus 1.
REQ-013 SHALL have port num_cols_in, input, $clog2(SYS_ARR_COLS) bits: valid columns minus 1.
REQ-014 SHALL have port accum_en, input, 1 bit: 1 = add into accumulator, 0 = overwrite.
REQ-015 SHALL have port busy, output, 1 bit: pass in progress.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse at end of pass.
REQ-017 SHALL have port wr_en, output, SYS_ARR_COLS bits: per-column accumulator write strobe.
REQ-018 SHALL have port wr_addr, output, SYS_ARR_COLS*AW bits: column c address at bits [c*AW +: AW].
REQ-019 SHALL have port wr_accum, output, SYS_ARR_COLS bits: per-column add(1)/overwrite(0) qualifier, valid only with wr_en.

Function
REQ-020 SHALL implement FSM states IDLE, WAIT, WRITE, FINISH.
REQ-021 SHALL accept start only in IDLE; on edge E0 with start=1, latch all *_in inputs and accum_en, then enter WAIT.
REQ-022 SHALL ignore start outside IDLE, and latched values SHALL NOT change mid-pass.
REQ-023 SHALL compute base = submat_col*MAX_OUT_ROWS + submat_row*SYS_ARR_ROWS, truncated to AW bits.
REQ-024 SHALL, for c ≤ num_cols and r ≤ num_rows, assert wr_en[c] with wr_addr[c] = base + r and wr_accum[c] = latched accum_en in the cycle following edge E0+LATENCY+r+c (diagonal skew of 1 cycle per column).
REQ-025 SHALL never assert wr_en[c] for c > num_cols, and at most num_rows+1 strobes per column per pass.
REQ-026 SHALL drive wr_addr[c] = 0 and wr_accum[c] = 0 whenever wr_en[c] = 0.
REQ-027 SHALL transition WAIT→WRITE at edge E0+LATENCY and WRITE→FINISH at edge E0+LATENCY+num_rows+num_cols+1.
REQ-028 SHALL hold done = 1 for exactly the FINISH cycle, then go to IDLE.
REQ-029 SHALL hold busy = 1 from the cycle after E0 through the last WRITE cycle, with busy = 0 in FINISH.
REQ-030 SHALL register all outputs (no combinational path from inputs to outputs).
REQ-031 SHALL accept a start asserted during the FINISH cycle on the next edge only if the FSM is in IDLE, giving a minimum 1 idle cycle between passes.

Reset
REQ-032 SHALL, while reset = 0 at a rising edge, force IDLE, busy = 0, done = 0, wr_en = 0, wr_addr = 0, wr_accum = 0, and clear all counters and latches.
REQ-033 SHALL, on reset mid-pass, abort immediately with no further wr_en and no done pulse.
REQ-034 SHALL give reset priority over start on the same edge.

Verification
REQ-035 Bench SHALL check: submat_row=2, submat_col=3, num_rows=15, num_cols=9, LATENCY=16, accum_en=1 -> base=416; wr_en[0] at E0+16 with addr 416; wr_en[9] last at E0+40 with addr 431; wr_en[15:10] never set; done at E0+41 only.
REQ-036 Bench SHALL check: num_rows=0, num_cols=0, submat 0/0 -> exactly one strobe, wr_en[0] at E0+16 with addr 0; done at E0+17.
REQ-037 Bench SHALL check: start pulsed again at E0+5 during a pass -> ignored; strobe count and done timing identical to a single pass.
REQ-038 Bench SHALL check: reset=0 at E0+20 -> all outputs 0 next cycle; no done; a new start afterwards runs normally.
REQ-039 Bench SHALL check: max indices submat_row=7, submat_col=7, num_rows=15, num_cols=15 -> addresses 1008..1023 in every column; wr_en[15] last at E0+46; done at E0+47.
REQ-040 Bench SHALL check: two back-to-back passes, with start held high continuously -> second E0 is one edge after FINISH; no overlap of strobes between passes.

Source files
------------

// File: rtl/accum_write_control.sv
// Accumulator write sequencer: after a start, emits diagonally skewed per-column
// write strobes and addresses for one systolic-array output submatrix.
module accum_write_control #(
  parameter int SYS_ARR_ROWS = 16,
  parameter int SYS_ARR_COLS = 16,
  parameter int MAX_OUT_ROWS = 128,
  parameter int MAX_OUT_COLS = 128,
  parameter int LATENCY      = 16,
  localparam int AW = $clog2(MAX_OUT_ROWS*(MAX_OUT_COLS/SYS_ARR_COLS))
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic [$clog2(MAX_OUT_ROWS/SYS_ARR_ROWS)-1:0] submat_row_in,
  input  logic [$clog2(MAX_OUT_COLS/SYS_ARR_COLS)-1:0] submat_col_in,
  input  logic [$clog2(SYS_ARR_ROWS)-1:0]              num_rows_in,
  input  logic [$clog2(SYS_ARR_COLS)-1:0]              num_cols_in,
  input  logic                                        accum_en,
  output logic                                        busy,
  output logic                                        done,
  output logic [SYS_ARR_COLS-1:0]                     wr_en,
  output logic [SYS_ARR_COLS*AW-1:0]                  wr_addr,
  output logic [SYS_ARR_COLS-1:0]                     wr_accum
);

  localparam int NRW = $clog2(SYS_ARR_ROWS);
  localparam int NCW = $clog2(SYS_ARR_COLS);
  // Cycle counter must reach LATENCY + num_rows + num_cols + 1.
  localparam int CW  = $clog2(LATENCY + SYS_ARR_ROWS + SYS_ARR_COLS + 1);
  localparam logic [CW-1:0] LAT_C = CW'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, WRITE, FINISH} state_t;

  state_t                    state_reg, state_next;
  logic [CW-1:0]             cnt_reg, cnt_next;
  logic [AW-1:0]             base_reg;
  logic [NRW-1:0]            nrows_reg;
  logic [NCW-1:0]            ncols_reg;
  logic [SYS_ARR_COLS-1:0]   col_mask_reg;
  logic                      accum_reg;
  logic                      busy_reg, busy_next;
  logic                      done_reg, done_next;
  logic [SYS_ARR_COLS-1:0]   wr_en_reg, wr_en_next;
  logic [SYS_ARR_COLS*AW-1:0] wr_addr_reg, wr_addr_next;
  logic [SYS_ARR_COLS-1:0]   wr_accum_reg, wr_accum_next;

  logic                      load;
  logic                      emit;
  logic [CW-1:0]             step;
  logic [CW-1:0]             last_step;
  logic [AW-1:0]             base_load;
  logic [SYS_ARR_COLS-1:0]   col_mask_load;

  // Base address is computed modulo 2^AW, matching the accumulator depth.
  assign base_load = AW'(submat_col_in) * AW'(MAX_OUT_ROWS)
                   + AW'(submat_row_in) * AW'(SYS_ARR_ROWS);
  assign col_mask_load = {SYS_ARR_COLS{1'b1}} >> (SYS_ARR_COLS - 1 - int'(num_cols_in));

  // step is the diagonal index (row + column) written on the upcoming edge.
  assign step      = cnt_reg - LAT_C;
  assign last_step = CW'(nrows_reg) + CW'(ncols_reg) + CW'(1);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    emit       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = WAIT;
          cnt_next   = CW'(1);
          load       = 1'b1;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == LAT_C) begin
          state_next = WRITE;
          emit       = 1'b1;
        end
      end
      WRITE: begin
        cnt_next = cnt_reg + CW'(1);
        if (step == last_step) begin
          state_next = FINISH;
        end else begin
          emit = 1'b1;
        end
      end
      FINISH: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    busy_next = (state_next == WAIT) || (state_next == WRITE);
    done_next = (state_next == FINISH);
  end

  genvar gi;
  generate
    for (gi = 0; gi < SYS_ARR_COLS; gi++) begin : g_col
      localparam logic [CW:0] COL_IDX = (CW+1)'(gi);
      logic [CW:0] row_diff;
      logic        hit;

      // A borrow out of row_diff means this column's diagonal has not arrived yet.
      assign row_diff = {1'b0, step} - COL_IDX;
      assign hit = emit && col_mask_reg[gi] && !row_diff[CW]
                && (row_diff[CW-1:0] <= CW'(nrows_reg));

      assign wr_en_next[gi]            = hit;
      assign wr_accum_next[gi]         = hit && accum_reg;
      assign wr_addr_next[gi*AW +: AW] = hit ? (base_reg + AW'(row_diff[CW-1:0])) : '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      base_reg     <= '0;
      nrows_reg    <= '0;
      ncols_reg    <= '0;
      col_mask_reg <= '0;
      accum_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      wr_en_reg    <= '0;
      wr_addr_reg  <= '0;
      wr_accum_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      wr_en_reg    <= wr_en_next;
      wr_addr_reg  <= wr_addr_next;
      wr_accum_reg <= wr_accum_next;
      if (load) begin
        base_reg     <= base_load;
        nrows_reg    <= num_rows_in;
        ncols_reg    <= num_cols_in;
        col_mask_reg <= col_mask_load;
        accum_reg    <= accum_en;
      end
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign wr_en    = wr_en_reg;
  assign wr_addr  = wr_addr_reg;
  assign wr_accum = wr_accum_reg;

endmodule
